// File: rtl/alu_pipe.sv
// Execute-stage ALU with valid/ready handshake and an iterative unsigned multiplier.
// Latency: 1 cycle for single-cycle ops; MUL gives out_valid WIDTH+1 cycles after accept.
// Backpressure: in_ready is low while a MUL iterates; a request seen then is ignored, not queued.
module alu_pipe #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       alu_control,
    input  logic [WIDTH-1:0] src,
    input  logic [WIDTH-1:0] dst,
    input  logic             flags_load,
    input  logic [3:0]       flags_in,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic [3:0]       flags
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [4:0] OP_SETC = 5'd1;
    localparam logic [4:0] OP_CLRC = 5'd2;
    localparam logic [4:0] OP_NOT  = 5'd3;
    localparam logic [4:0] OP_INC  = 5'd4;
    localparam logic [4:0] OP_DEC  = 5'd5;
    localparam logic [4:0] OP_MOV  = 5'd8;
    localparam logic [4:0] OP_ADD  = 5'd9;
    localparam logic [4:0] OP_SUB  = 5'd10;
    localparam logic [4:0] OP_AND  = 5'd11;
    localparam logic [4:0] OP_OR   = 5'd12;
    localparam logic [4:0] OP_SHL  = 5'd13;
    localparam logic [4:0] OP_SHR  = 5'd14;
    localparam logic [4:0] OP_PUSH = 5'd15;
    localparam logic [4:0] OP_POP  = 5'd16;
    localparam logic [4:0] OP_LDM  = 5'd17;
    localparam logic [4:0] OP_ADC  = 5'd27;
    localparam logic [4:0] OP_MUL  = 5'd28;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_result;
    logic [3:0]           r_flags;
    logic                 r_out_valid;
    logic                 r_in_ready;
    logic [2*WIDTH-1:0]   r_acc;     // upper half: partial product, lower half: remaining multiplier bits
    logic [WIDTH-1:0]     r_mcand;
    logic [CNT_W-1:0]     r_cnt;

    logic [WIDTH-1:0]     w_res;
    logic [3:0]           w_flg;
    logic                 w_zn;
    logic                 w_start_mul;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_shl;
    logic [WIDTH:0]       w_shr;
    logic [SHAMT_W-1:0]   w_amt;
    logic [WIDTH:0]       w_mul_add;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic [WIDTH-1:0]     w_prod_lo;
    logic                 w_prod_hi_nz;

    assign result    = r_result;
    assign flags     = r_flags;
    assign out_valid = r_out_valid;
    assign in_ready  = r_in_ready;

    // Single-cycle op datapath: next result/flags for the op presented this cycle
    always_comb begin
        w_res       = r_result;
        w_flg       = r_flags;
        w_zn        = 1'b0;
        w_start_mul = 1'b0;
        w_amt       = dst[SHAMT_W-1:0];
        w_sum       = '0;
        w_shl       = {1'b0, src} << w_amt;
        w_shr       = {src, 1'b0} >> w_amt;
        case (alu_control)
            OP_SETC: w_flg[0] = 1'b1;
            OP_CLRC: w_flg[0] = 1'b0;
            OP_NOT: begin
                w_res = ~dst;
                w_zn  = 1'b1;
            end
            OP_INC: begin
                w_res = dst + {{(WIDTH-1){1'b0}}, 1'b1};
                w_zn  = 1'b1;
            end
            OP_DEC: begin
                w_res = dst - {{(WIDTH-1){1'b0}}, 1'b1};
                w_zn  = 1'b1;
            end
            OP_MOV, OP_PUSH, OP_POP, OP_LDM: w_res = src;
            OP_ADD, OP_ADC: begin
                w_sum    = {1'b0, src} + {1'b0, dst}
                         + {{WIDTH{1'b0}}, (alu_control == OP_ADC) & r_flags[0]};
                w_res    = w_sum[WIDTH-1:0];
                w_flg[0] = w_sum[WIDTH];
                w_flg[3] = (src[WIDTH-1] == dst[WIDTH-1]) && (w_sum[WIDTH-1] != src[WIDTH-1]);
                w_zn     = 1'b1;
            end
            OP_SUB: begin
                w_res    = src - dst;
                w_flg[0] = (src < dst);
                w_flg[3] = (src[WIDTH-1] != dst[WIDTH-1]) && (w_res[WIDTH-1] == dst[WIDTH-1]);
                w_zn     = 1'b1;
            end
            OP_AND: begin
                w_res = src & dst;
                w_zn  = 1'b1;
            end
            OP_OR: begin
                w_res = src | dst;
                w_zn  = 1'b1;
            end
            OP_SHL: begin
                w_res = w_shl[WIDTH-1:0];
                if (w_amt != '0) w_flg[0] = w_shl[WIDTH];
            end
            OP_SHR: begin
                w_res = w_shr[WIDTH:1];
                if (w_amt != '0) w_flg[0] = w_shr[0];
            end
            OP_MUL: w_start_mul = 1'b1;
            default: ; // NOP, OUT, IN, LDD, STD, branch/call/return codes, unused codes
        endcase
        if (w_zn) begin
            w_flg[1] = (w_res == '0);
            w_flg[2] = w_res[WIDTH-1];
        end
    end

    // One shift-add step of the multiplier and the product it yields after the last step
    always_comb begin
        w_mul_add    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
        w_acc_next   = {w_mul_add, r_acc[WIDTH-1:1]};
        w_prod_lo    = w_acc_next[WIDTH-1:0];
        w_prod_hi_nz = |w_acc_next[2*WIDTH-1:WIDTH];
    end

    // Control FSM with registered result, flags and handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_result    <= '0;
            r_flags     <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_cnt       <= '0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (w_start_mul) begin
                            r_state    <= S_MUL;
                            r_in_ready <= 1'b0;
                            r_acc      <= {{WIDTH{1'b0}}, dst};
                            r_mcand    <= src;
                            r_cnt      <= CNT_W'(WIDTH);
                        end else begin
                            r_result    <= w_res;
                            r_flags     <= w_flg;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state     <= S_IDLE;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_result    <= w_prod_lo;
                        r_flags     <= {w_prod_hi_nz, w_prod_lo[WIDTH-1],
                                        (w_prod_lo == '0), w_prod_hi_nz};
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            // Flag restore overrides any flag update from an op completing at the same edge
            if (flags_load) r_flags <= flags_in;
        end
    end

endmodule
